uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 4-state bit-timing FSM and a 32x8
// show-ahead FIFO (31 usable slots) with framing-error and overrun pulses.
module uart_rx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div_i,
  input  logic        rx_i,
  input  logic        re_i,
  output logic [7:0]  data_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned BW    = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            meta_q, rx_s_q, rx_dly_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            start_det_c;
  logic            push_c;
  logic            pop_c;
  logic [CW-1:0]   half_c;

  // Line synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_dly_q <= 1'b1;
    end else begin
      meta_q   <= rx_i;
      rx_s_q   <= meta_q;
      rx_dly_q <= rx_s_q;
    end
  end

  assign start_det_c = rx_dly_q & ~rx_s_q;
  assign half_c      = baud_div_i >> 1;
  assign empty_o     = (rd_ptr_q == wr_ptr_q);
  assign full_o      = (AW'(wr_ptr_q + AW'(1)) == rd_ptr_q);
  assign pop_c       = re_i & ~empty_o;
  assign data_o      = mem_q[rd_ptr_q];
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  // Bit-timing FSM; >= compares keep a mid-frame divisor change from running the counter away
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_det_c) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q >= half_c) begin
          if (!rx_s_q) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
      DATA: begin
        if (cnt_q >= baud_div_i) begin
          shift_d   = {rx_s_q, shift_q[DW-1:1]};
          cnt_d     = '0;
          bit_idx_d = BW'(bit_idx_q + BW'(1));
          if (bit_idx_q == BW'(DW - 1)) state_d = STOP;
        end else begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
      STOP: begin
        if (cnt_q >= baud_div_i) begin
          state_d = IDLE;
          if (rx_s_q) begin
            if (full_o) overrun_d = 1'b1;
            else        push_c    = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = AW'(wr_ptr_q + AW'(1));
    if (pop_c)  rd_ptr_d = AW'(rd_ptr_q + AW'(1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= shift_q;
  end

endmodule
